// File: rtl/ac_alu_pkg.sv
// Shared encodings for the accumulator stage and the control-unit decoder.
package ac_alu_pkg;

   localparam int unsigned AC_WIDTH = 16;

   typedef enum logic [3:0] {
      AC_NOP = 4'd0,
      AC_AND = 4'd1,
      AC_ADD = 4'd2,
      AC_LDA = 4'd3,
      AC_CLA = 4'd4,
      AC_CMA = 4'd5,
      AC_CIR = 4'd6,
      AC_CIL = 4'd7,
      AC_INC = 4'd8,
      AC_INP = 4'd9
   } ac_op_e;

   typedef enum logic [1:0] {
      E_NOP = 2'd0,
      E_CLE = 2'd1,
      E_CME = 2'd2
   } e_op_e;

endpackage

// File: rtl/ac_alu_core.sv
// Combinational next-state logic for AC and E.
module ac_alu_core
   import ac_alu_pkg::*;
#(
   parameter int unsigned WIDTH = AC_WIDTH
) (
   input  logic [WIDTH-1:0] AC,
   input  logic             E,
   input  logic [WIDTH-1:0] DR,
   input  logic [7:0]       INPR,
   input  logic [3:0]       acOP,
   input  logic [1:0]       eOP,
   output logic [WIDTH-1:0] next_AC,
   output logic             next_E
);

   logic [WIDTH:0] sum;
   logic           e_written;

   assign sum = {1'b0, AC} + {1'b0, DR};

   // Select AC result; ADD/CIR/CIL also own E, otherwise eOP decides E.
   always_comb begin
      next_AC   = AC;
      next_E    = E;
      e_written = 1'b0;
      case (acOP)
         AC_AND: next_AC = AC & DR;
         AC_ADD: begin
            {next_E, next_AC} = sum;
            e_written         = 1'b1;
         end
         AC_LDA: next_AC = DR;
         AC_CLA: next_AC = '0;
         AC_CMA: next_AC = ~AC;
         AC_CIR: begin
            next_AC   = {E, AC[WIDTH-1:1]};
            next_E    = AC[0];
            e_written = 1'b1;
         end
         AC_CIL: begin
            next_AC   = {AC[WIDTH-2:0], E};
            next_E    = AC[WIDTH-1];
            e_written = 1'b1;
         end
         AC_INC: next_AC = AC + {{(WIDTH-1){1'b0}}, 1'b1};
         AC_INP: next_AC = {AC[WIDTH-1:8], INPR};
         default: next_AC = AC;
      endcase
      if (!e_written) begin
         case (eOP)
            E_CLE:   next_E = 1'b0;
            E_CME:   next_E = ~E;
            default: next_E = E;
         endcase
      end
   end

endmodule

// File: rtl/ac_alu.sv
// Accumulator/E register stage with AC status flags.
module ac_alu
   import ac_alu_pkg::*;
#(
   parameter int unsigned WIDTH = AC_WIDTH
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic [WIDTH-1:0] DR,
   input  logic [7:0]       INPR,
   input  logic [3:0]       acOP,
   input  logic [1:0]       eOP,
   output logic [WIDTH-1:0] AC,
   output logic             E,
   output logic             acZero,
   output logic             acNeg
);

   logic [WIDTH-1:0] next_AC;
   logic             next_E;

   ac_alu_core #(.WIDTH(WIDTH)) u_core (
      .AC      (AC),
      .E       (E),
      .DR      (DR),
      .INPR    (INPR),
      .acOP    (acOP),
      .eOP     (eOP),
      .next_AC (next_AC),
      .next_E  (next_E)
   );

   // AC and E registers, cleared asynchronously.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         AC <= '0;
         E  <= 1'b0;
      end else begin
         AC <= next_AC;
         E  <= next_E;
      end
   end

   // Status flags straight from the registered AC.
   always_comb begin
      acZero = (AC == '0);
      acNeg  = AC[WIDTH-1];
   end

endmodule

// File: tb/tb_ac_alu.sv
// Self-checking bench for ac_alu: behavioural model, per-cycle compare,
// directed literal expectations and randomized stimulus.
module tb_ac_alu;

   logic        CLK;
   logic        RST_N;
   logic [15:0] DR;
   logic [7:0]  INPR;
   logic [3:0]  acOP;
   logic [1:0]  eOP;
   logic [15:0] AC;
   logic        E;
   logic        acZero;
   logic        acNeg;

   int checks   = 0;
   int failures = 0;
   bit cmp_en   = 0;

   int unsigned m_ac;
   int unsigned m_e;

   ac_alu #(.WIDTH(16)) dut (
      .CLK    (CLK),
      .RST_N  (RST_N),
      .DR     (DR),
      .INPR   (INPR),
      .acOP   (acOP),
      .eOP    (eOP),
      .AC     (AC),
      .E      (E),
      .acZero (acZero),
      .acNeg  (acNeg)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string name, input int unsigned act, input int unsigned exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference model: plain integer arithmetic on the architectural rules.
   always @(posedge CLK or negedge RST_N) begin
      int unsigned a, d, s;
      if (!RST_N) begin
         m_ac = 0;
         m_e  = 0;
      end else begin
         a = m_ac;
         d = DR;
         case (int'(acOP))
            1: m_ac = a & d;
            2: begin
               s    = a + d;
               m_ac = s % 65536;
               m_e  = s / 65536;
            end
            3: m_ac = d;
            4: m_ac = 0;
            5: m_ac = 65535 - a;
            6: begin
               m_ac = m_e * 32768 + a / 2;
               m_e  = a % 2;
            end
            7: begin
               m_ac = (a * 2) % 65536 + m_e;
               m_e  = a / 32768;
            end
            8: m_ac = (a + 1) % 65536;
            9: m_ac = (a / 256) * 256 + int'(INPR);
            default: ;
         endcase
         if (!(acOP == 2 || acOP == 6 || acOP == 7)) begin
            if (eOP == 1) m_e = 0;
            else if (eOP == 2) m_e = 1 - m_e;
         end
      end
   end

   // Every-cycle comparison of DUT outputs against the model.
   always @(negedge CLK) begin
      if (cmp_en && RST_N) begin
         chk("cyc_AC", AC, m_ac);
         chk("cyc_E", E, m_e);
         chk("cyc_acZero", acZero, (m_ac == 0) ? 1 : 0);
         chk("cyc_acNeg", acNeg, m_ac / 32768);
      end
   end

   task automatic doop(input logic [3:0] op, input logic [1:0] eo,
                       input logic [15:0] d, input logic [7:0] inp);
      @(negedge CLK);
      acOP = op;
      eOP  = eo;
      DR   = d;
      INPR = inp;
      @(posedge CLK);
      #1;
   endtask

   // Literal expectation pinned on both the DUT and the model.
   task automatic expect_st(input string name, input int unsigned ac_x, input int unsigned e_x);
      chk({name, "_AC"}, AC, ac_x);
      chk({name, "_E"}, E, e_x);
      chk({name, "_modelAC"}, m_ac, ac_x);
      chk({name, "_modelE"}, m_e, e_x);
   endtask

   initial begin
      RST_N = 1'b0;
      DR    = '0;
      INPR  = '0;
      acOP  = 4'd0;
      eOP   = 2'd0;
      #2;
      chk("rst_AC", AC, 0);
      chk("rst_E", E, 0);
      chk("rst_acZero", acZero, 1);
      chk("rst_acNeg", acNeg, 0);
      @(negedge CLK);
      RST_N  = 1'b1;
      cmp_en = 1;

      // Asynchronous reset between edges
      doop(4'd3, 2'd0, 16'h1234, 8'h00);
      expect_st("lda1234", 16'h1234, 0);
      RST_N = 1'b0;
      #2;
      chk("midrst_AC", AC, 0);
      chk("midrst_E", E, 0);
      chk("midrst_acZero", acZero, 1);
      RST_N = 1'b1;

      // ADD carry boundary
      doop(4'd3, 2'd0, 16'hFFFF, 8'h00);
      doop(4'd2, 2'd0, 16'h0001, 8'h00);
      expect_st("add_wrap", 16'h0000, 1);
      chk("add_wrap_zero", acZero, 1);
      doop(4'd2, 2'd0, 16'h7FFF, 8'h00);
      expect_st("add_7fff", 16'h7FFF, 0);

      // Rotate through E
      doop(4'd0, 2'd1, 16'h0000, 8'h00);
      doop(4'd0, 2'd2, 16'h0000, 8'h00);
      doop(4'd3, 2'd0, 16'h8001, 8'h00);
      expect_st("lda8001", 16'h8001, 1);
      doop(4'd6, 2'd0, 16'h0000, 8'h00);
      expect_st("cir", 16'hC000, 1);
      doop(4'd7, 2'd0, 16'h0000, 8'h00);
      expect_st("cil", 16'h8001, 1);

      // Logic / INC / INP
      doop(4'd3, 2'd0, 16'h00F0, 8'h00);
      doop(4'd1, 2'd0, 16'h0FF0, 8'h00);
      expect_st("and", 16'h00F0, 1);
      doop(4'd5, 2'd0, 16'h0000, 8'h00);
      expect_st("cma", 16'hFF0F, 1);
      chk("cma_acNeg", acNeg, 1);
      doop(4'd8, 2'd0, 16'h0000, 8'h00);
      expect_st("inc", 16'hFF10, 1);
      doop(4'd9, 2'd0, 16'h0000, 8'h41);
      expect_st("inp", 16'hFF41, 1);

      // INC wrap keeps E
      doop(4'd3, 2'd0, 16'hFFFF, 8'h00);
      doop(4'd8, 2'd0, 16'h0000, 8'h00);
      expect_st("inc_wrap", 16'h0000, 1);

      // ADD carry beats eOP
      doop(4'd0, 2'd1, 16'h0000, 8'h00);
      doop(4'd3, 2'd0, 16'h8000, 8'h00);
      expect_st("lda8000", 16'h8000, 0);
      doop(4'd2, 2'd1, 16'h8000, 8'h00);
      expect_st("add_prec", 16'h0000, 1);

      // Reserved op with eOP=3 holds state
      doop(4'd12, 2'd3, 16'hAAAA, 8'h00);
      doop(4'd12, 2'd3, 16'h5555, 8'h00);
      doop(4'd12, 2'd3, 16'hAAAA, 8'h00);
      expect_st("reserved", 16'h0000, 1);

      // Randomized stimulus against the model
      for (int i = 0; i < 2000; i++) begin
         doop(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
              16'($urandom), 8'($urandom));
         if (i == 1000) begin
            RST_N = 1'b0;
            #1;
            chk("rnd_rst_AC", AC, 0);
            chk("rnd_rst_E", E, 0);
            RST_N = 1'b1;
         end
      end

      @(negedge CLK);
      cmp_en = 0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
